// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// The requester enum is also used as the round-robin "last granted" marker.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    localparam int DMEM_DEF_AW = 32;
    localparam int DMEM_DEF_DW = 32;
    localparam int DMEM_DEF_CW = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker with a 1-bit last-grant register.
// state | meaning
// ------+---------------------------------------------------
// CPU   | CPU granted most recently; DBG wins the next tie
// DBG   | DBG granted most recently (reset); CPU wins the next tie
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_cpu,
    input  logic req_dbg,
    output logic gnt_cpu,
    output logic gnt_dbg
);

    req_id_e last;

    // Grants are combinational so a lone requester never loses a cycle;
    // reset suppresses any grant in the same cycle.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
        if (!reset) begin
            if (req_cpu && req_dbg) begin
                if (last == REQ_DBG) begin
                    gnt_cpu = 1'b1;
                end else begin
                    gnt_dbg = 1'b1;
                end
            end else begin
                gnt_cpu = req_cpu;
                gnt_dbg = req_dbg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= REQ_DBG;
        end else if (gnt_cpu) begin
            last <= REQ_CPU;
        end else if (gnt_dbg) begin
            last <= REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the CPU MEM stage and the debug/loader port onto one
// single-port data memory; tracks read returns and counts grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_DEF_AW,
    parameter int DW = DMEM_DEF_DW,
    parameter int CW = DMEM_DEF_CW
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rd,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wd,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rd,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,

    output logic [CW-1:0] cnt_cpu,
    output logic [CW-1:0] cnt_dbg
);

    logic    rd_pend;
    req_id_e rd_owner;
    logic    rd_issue;

    rr_pick2 u_pick (
        .clk     (clk),
        .reset   (reset),
        .req_cpu (cpu_req),
        .req_dbg (dbg_req),
        .gnt_cpu (cpu_gnt),
        .gnt_dbg (dbg_gnt)
    );

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory bus is zero whenever nobody holds the grant.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (cpu_gnt) begin
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
        end else if (dbg_gnt) begin
            mem_we   = dbg_we;
            mem_addr = dbg_addr;
            mem_wd   = dbg_wd;
        end
    end

    assign rd_issue = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= REQ_CPU;
            cnt_cpu  <= '0;
            cnt_dbg  <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (cpu_gnt) begin
                rd_owner <= REQ_CPU;
            end else if (dbg_gnt) begin
                rd_owner <= REQ_DBG;
            end
            if (cpu_gnt && !(&cnt_cpu)) begin
                cnt_cpu <= cnt_cpu + 1'b1;
            end
            if (dbg_gnt && !(&cnt_dbg)) begin
                cnt_dbg <= cnt_dbg + 1'b1;
            end
        end
    end

    // A read still in flight when reset rises is dropped, hence the gate.
    assign cpu_rvalid = ~reset & rd_pend & (rd_owner == REQ_CPU);
    assign dbg_rvalid = ~reset & rd_pend & (rd_owner == REQ_DBG);
    assign cpu_rd     = cpu_rvalid ? mem_rd : '0;
    assign dbg_rd     = dbg_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; second instance with CW=2 covers saturation.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wd;
    logic [31:0] mem_rd;

    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rd;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rd;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd;
    logic [15:0] cnt_cpu, cnt_dbg;

    logic        s_cpu_gnt, s_cpu_stall, s_cpu_rvalid;
    logic [31:0] s_cpu_rd;
    logic        s_dbg_gnt, s_dbg_rvalid;
    logic [31:0] s_dbg_rd;
    logic        s_mem_we;
    logic [31:0] s_mem_addr, s_mem_wd;
    logic [1:0]  s_cnt_cpu, s_cnt_dbg;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .cnt_cpu(cnt_cpu), .cnt_dbg(cnt_dbg)
    );

    dmem_arbiter #(.AW(32), .DW(32), .CW(2)) u_sat (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(s_cpu_gnt), .cpu_stall(s_cpu_stall), .cpu_rvalid(s_cpu_rvalid), .cpu_rd(s_cpu_rd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
        .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rd(s_dbg_rd),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd), .mem_rd(mem_rd),
        .cnt_cpu(s_cnt_cpu), .cnt_dbg(s_cnt_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: read data valid one cycle after the address.
    always @(posedge clk) mem_rd <= data_of(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wd = d;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wd = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive_cpu(1'b1, 1'b1, 32'h44, 32'h99);
        drive_dbg(1'b1, 1'b0, 32'h48, 32'h0);

        // Reset held with both ports requesting
        tick();
        chk("rst_cpu_gnt",   64'(cpu_gnt),    64'(0));
        chk("rst_dbg_gnt",   64'(dbg_gnt),    64'(0));
        chk("rst_cpu_stall", 64'(cpu_stall),  64'(1));
        chk("rst_mem_we",    64'(mem_we),     64'(0));
        chk("rst_cpu_rv",    64'(cpu_rvalid), 64'(0));
        chk("rst_dbg_rv",    64'(dbg_rvalid), 64'(0));
        chk("rst_cpu_rd",    64'(cpu_rd),     64'(0));
        chk("rst_cnt_cpu",   64'(cnt_cpu),    64'(0));
        chk("rst_cnt_dbg",   64'(cnt_dbg),    64'(0));

        reset = 1'b0;
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("idle_mem_we",   64'(mem_we),   64'(0));
        chk("idle_mem_addr", 64'(mem_addr), 64'(0));
        chk("idle_mem_wd",   64'(mem_wd),   64'(0));
        chk("idle_gnt",      64'({cpu_gnt, dbg_gnt}), 64'(0));

        // Single CPU read of 0x10
        drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("rd1_cpu_gnt",   64'(cpu_gnt),   64'(1));
        chk("rd1_dbg_gnt",   64'(dbg_gnt),   64'(0));
        chk("rd1_stall",     64'(cpu_stall), 64'(0));
        chk("rd1_mem_addr",  64'(mem_addr),  64'(32'h10));
        chk("rd1_mem_we",    64'(mem_we),    64'(0));
        tick();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rd1_cpu_rv",    64'(cpu_rvalid), 64'(1));
        chk("rd1_cpu_rd",    64'(cpu_rd),     64'(32'hDEAD_BEEF));
        chk("rd1_dbg_rv",    64'(dbg_rvalid), 64'(0));
        chk("rd1_dbg_rd",    64'(dbg_rd),     64'(0));
        chk("rd1_cnt_cpu",   64'(cnt_cpu),    64'(1));
        tick();
        chk("rd1_rv_once",   64'(cpu_rvalid), 64'(0));
        chk("rd1_rd_zero",   64'(cpu_rd),     64'(0));

        // Fresh reset, then both write continuously for 6 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_cpu(1'b1, 1'b1, 32'h100, 32'h1);
        drive_dbg(1'b1, 1'b1, 32'h200, 32'h2);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("tie%0d_cpu_gnt", i), 64'(cpu_gnt),   64'((i % 2) == 0));
            chk($sformatf("tie%0d_dbg_gnt", i), 64'(dbg_gnt),   64'((i % 2) == 1));
            chk($sformatf("tie%0d_stall", i),   64'(cpu_stall), 64'((i % 2) == 1));
            chk($sformatf("tie%0d_addr", i),    64'(mem_addr),  ((i % 2) == 0) ? 64'h100 : 64'h200);
            chk($sformatf("tie%0d_wd", i),      64'(mem_wd),    ((i % 2) == 0) ? 64'h1 : 64'h2);
            tick();
        end
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("tie_cnt_cpu",   64'(cnt_cpu),    64'(3));
        chk("tie_cnt_dbg",   64'(cnt_dbg),    64'(3));
        chk("tie_no_rv",     64'({cpu_rvalid, dbg_rvalid}), 64'(0));

        // Back-to-back reads: CPU 0x4 (tie, last=DBG), DBG 0x8 (tie), CPU 0xC
        drive_cpu(1'b1, 1'b0, 32'h4, 32'h0);
        drive_dbg(1'b1, 1'b0, 32'h8, 32'h0);
        #1;
        chk("b2b_a_cpu_gnt", 64'(cpu_gnt), 64'(1));
        chk("b2b_a_dbg_gnt", 64'(dbg_gnt), 64'(0));
        tick();
        drive_cpu(1'b1, 1'b0, 32'hC, 32'h0);
        #1;
        chk("b2b_b_dbg_gnt", 64'(dbg_gnt),    64'(1));
        chk("b2b_b_stall",   64'(cpu_stall),  64'(1));
        chk("b2b_b_cpu_rv",  64'(cpu_rvalid), 64'(1));
        chk("b2b_b_cpu_rd",  64'(cpu_rd),     64'(32'hC0DE_0004));
        chk("b2b_b_dbg_rv",  64'(dbg_rvalid), 64'(0));
        chk("b2b_b_dbg_rd",  64'(dbg_rd),     64'(0));
        tick();
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("b2b_c_cpu_gnt", 64'(cpu_gnt),    64'(1));
        chk("b2b_c_dbg_rv",  64'(dbg_rvalid), 64'(1));
        chk("b2b_c_dbg_rd",  64'(dbg_rd),     64'(32'hC0DE_0008));
        chk("b2b_c_cpu_rv",  64'(cpu_rvalid), 64'(0));
        chk("b2b_c_cpu_rd",  64'(cpu_rd),     64'(0));
        tick();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("b2b_d_cpu_rv",  64'(cpu_rvalid), 64'(1));
        chk("b2b_d_cpu_rd",  64'(cpu_rd),     64'(32'hC0DE_000C));
        chk("b2b_d_dbg_rv",  64'(dbg_rvalid), 64'(0));
        tick();
        chk("b2b_e_rv",      64'({cpu_rvalid, dbg_rvalid}), 64'(0));

        // DBG write 0x20 <- 0x55
        drive_dbg(1'b1, 1'b1, 32'h20, 32'h55);
        #1;
        chk("wr_dbg_gnt",    64'(dbg_gnt),  64'(1));
        chk("wr_mem_we",     64'(mem_we),   64'(1));
        chk("wr_mem_addr",   64'(mem_addr), 64'(32'h20));
        chk("wr_mem_wd",     64'(mem_wd),   64'(32'h55));
        tick();
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("wr_no_rv",      64'({cpu_rvalid, dbg_rvalid}), 64'(0));

        // CPU read granted, reset rises next cycle with a CPU write pending
        drive_cpu(1'b1, 1'b0, 32'h30, 32'h0);
        #1;
        chk("rr_cpu_gnt",    64'(cpu_gnt), 64'(1));
        tick();
        reset = 1'b1;
        drive_cpu(1'b1, 1'b1, 32'h34, 32'h77);
        #1;
        chk("rr_cpu_rv",     64'(cpu_rvalid), 64'(0));
        chk("rr_cpu_rd",     64'(cpu_rd),     64'(0));
        chk("rr_gnt_supp",   64'(cpu_gnt),    64'(0));
        chk("rr_we_supp",    64'(mem_we),     64'(0));
        chk("rr_stall",      64'(cpu_stall),  64'(1));
        tick();
        reset = 1'b0;
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rr_post_rv",    64'(cpu_rvalid), 64'(0));
        chk("rr_cnt_cpu",    64'(cnt_cpu),    64'(0));
        chk("rr_cnt_dbg",    64'(cnt_dbg),    64'(0));
        drive_cpu(1'b1, 1'b1, 32'h40, 32'h1);
        drive_dbg(1'b1, 1'b1, 32'h50, 32'h2);
        #1;
        chk("rr_tie_cpu",    64'(cpu_gnt), 64'(1));
        chk("rr_tie_dbg",    64'(dbg_gnt), 64'(0));
        tick();

        // DBG alone for 5 grants: CW=2 instance saturates at 3
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dbg(1'b1, 1'b1, 32'h60, 32'h3);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("sat%0d_gnt", i), 64'(s_dbg_gnt), 64'(1));
            tick();
            chk($sformatf("sat%0d_cnt", i), 64'(s_cnt_dbg), (i < 2) ? 64'(i + 1) : 64'(3));
        end
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("sat_hold",      64'(s_cnt_dbg), 64'(3));
        chk("sat_cnt_cpu",   64'(s_cnt_cpu), 64'(1));
        chk("wide_cnt_dbg",  64'(cnt_dbg),   64'(5));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
